cdc_bus_rx: RTL and testbench
=============================

# cdc_bus_rx

Parametrised receive side of a two-phase (toggle) request/acknowledge bus crossing, clocked entirely in the destination domain. It synchronises an asynchronous request toggle through a configurable synchroniser chain and qualifies a quasi-static multi-bit data bus by requiring it to be stable for several consecutive cycles. It then presents the word on a valid/ready interface and returns an acknowledge toggle to the sender. It replaces fixed two-flop per-bit bus synchronisers on the AHB-to-APB bridge's wide paths (Prdata, Paddr/Pwdata), adding a handshake, stability checking, backpressure and error reporting.

## Interface
- WIDTH, 32, data bus width (≥1)
- SYNC_STAGES, 2, flops in the request synchroniser chain (≥2)
- STABLE_CYCLES, 2, consecutive equal samples required before capture (≥1)
- MAX_WAIT, 8, CAPTURE-state cycle budget before abort (> STABLE_CYCLES)

Ports:
- Hclk  in  1  destination clock; only clock in the block
- Hreset  in  1  synchronous, active-high reset
- req_tgl_async  in  1  request toggle from sender domain (asynchronous)
- data_async  in  WIDTH  sender data; held stable by the sender from before req toggle until ack toggle
- out_ready  in  1  consumer accepts data_out
- data_out  out  WIDTH  captured word; held until next successful capture
- data_valid  out  1  data_out valid, level, held until out_ready
- ack_tgl  out  1  acknowledge toggle to sender
- busy  out  1  state ≠ IDLE
- err_unstable  out  1  one-cycle pulse on capture abort
- err_protocol  out  1  one-cycle pulse on request toggle while busy

## Operation
- Synchroniser: shift chain req_sync[SYNC_STAGES-1:0]; req_s = last stage; req_s_d = req_s delayed one cycle; req_seen = last accepted request level.
- Edge = (req_s ≠ req_seen).
- IDLE: on edge, req_seen ← req_s; samp ← data_async; cnt ← 0; wait_cnt ← 0; go to CAPTURE.
- CAPTURE, every cycle:
  - samp ← data_async; wait_cnt ← wait_cnt+1.
  - If data_async == samp: cnt ← cnt+1, else cnt ← 0.
  - Success, checked first: data_async == samp and cnt == STABLE_CYCLES-1 → data_out ← data_async, go to VALID.
  - Otherwise, if wait_cnt == MAX_WAIT-1 → err_unstable pulse, ack_tgl toggles, data_out unchanged, go to IDLE.
- VALID: data_valid = 1. When out_ready = 1, ack_tgl toggles and state goes to IDLE; data_valid is 0 the next cycle.
- Protocol error: err_protocol pulses on any cycle with req_s ≠ req_s_d and state ≠ IDLE. Capture continues unaffected.
  - After return to IDLE, a net-pending edge (odd number of extra toggles) starts a new capture.
  - An even number of extra toggles starts nothing.
- Counters are $clog2(MAX_WAIT+1) bits wide and never wrap (bounded by the MAX_WAIT abort).
- Reset (any state, including mid-capture or VALID):
  - All sync flops, req_s_d, req_seen, ack_tgl, data_out, data_valid, busy, err_unstable, err_protocol are 0; state is IDLE.
  - The sender must be reset concurrently.

## Timing
- Request toggle first sampled at edge k:
  - req_s changes at edge k+SYNC_STAGES-1.
  - CAPTURE entered at k+SYNC_STAGES.
  - With stable data, data_valid is high from edge k+SYNC_STAGES+STABLE_CYCLES.
- Defaults: valid 4 cycles after first sampling.
- ack_tgl changes at the edge where valid&ready is sampled, or at the abort edge.
- out_ready high while data_valid is high: one-cycle VALID.
- Abort: err_unstable high for exactly the cycle after edge k+SYNC_STAGES+MAX_WAIT-1. busy falls on the same edge.
- Minimum round trip (toggle sampled → next toggle acceptable) is SYNC_STAGES+STABLE_CYCLES+1 cycles plus sender-side ack synchronisation.

## Test plan
- Reset with defaults:
  - Hreset high 3 cycles → all outputs 0, busy 0.
  - Release, no toggle for 20 cycles → outputs unchanged.
- Basic transfer:
  - data_async = 0xA5A5_1234, toggle req at edge 10, out_ready tied 1.
  - Expected: data_valid high only during cycle after edge 14, data_out = 0xA5A5_1234, ack_tgl 0→1 at edge 15.
- Backpressure:
  - As the basic transfer but out_ready low until edge 20.
  - Expected: data_valid high edges 14–20, data_out stable, ack_tgl toggles at edge 20 only.
- Instability abort:
  - data_async changes every cycle after the toggle.
  - Expected: no data_valid, err_unstable single pulse after edge k+2+8-1, ack_tgl toggles, data_out keeps previous value.
- Protocol error:
  - Second toggle while in CAPTURE.
  - Expected: one err_protocol pulse, first word delivered correctly, second capture starts immediately after return to IDLE.
  - Repeat with two extra toggles: no second capture.
- Reset mid-VALID and parameter sweep:
  - Hreset asserted during VALID → data_valid, ack_tgl, data_out 0 next cycle.
  - Rerun the basic transfer with WIDTH=8, SYNC_STAGES=3, STABLE_CYCLES=1: valid at k+4.

Source files
------------

// File: rtl/cdc_bus_rx_if.sv
// Signal bundle for the destination side of a toggle-handshake bus crossing.
// slave = receiver (cdc_bus_rx), master = the sender/consumer pair driving it.
interface cdc_bus_rx_if #(
    parameter int WIDTH = 32
);
    logic             req_tgl_async;
    logic [WIDTH-1:0] data_async;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             ack_tgl;
    logic             busy;
    logic             err_unstable;
    logic             err_protocol;

    modport slave (
        input  req_tgl_async, data_async, out_ready,
        output data_out, data_valid, ack_tgl, busy, err_unstable, err_protocol
    );

    modport master (
        output req_tgl_async, data_async, out_ready,
        input  data_out, data_valid, ack_tgl, busy, err_unstable, err_protocol
    );
endinterface

// File: rtl/cdc_bus_rx.sv
// Receive side of a two-phase request/ack bus crossing: synchronises the request
// toggle, waits for the quasi-static data bus to settle, then hands it off valid/ready.
module cdc_bus_rx #(
    parameter int WIDTH         = 32,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 2,
    parameter int MAX_WAIT      = 8
) (
    input  logic        Hclk,
    input  logic        Hreset,
    cdc_bus_rx_if.slave bus
);
    localparam int              CW          = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0]   STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]   WAIT_LAST   = CW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, VALID} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] req_sync;
    logic                   req_s;
    logic                   req_s_d;
    logic                   req_seen;
    logic [WIDTH-1:0]       samp;
    logic [WIDTH-1:0]       data_out_q;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          wait_cnt;
    logic [CW-1:0]          wait_nxt;
    logic                   same;
    logic                   data_valid_q;
    logic                   ack_q;
    logic                   err_unst_q;
    logic                   err_prot_q;

    assign req_s    = req_sync[SYNC_STAGES-1];
    assign same     = (bus.data_async == samp);
    // Abort fires on the edge that brings the count to MAX_WAIT-1, so the abort
    // lands MAX_WAIT-1 edges after CAPTURE entry.
    assign wait_nxt = wait_cnt + CW'(1);

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state        <= IDLE;
            req_sync     <= '0;
            req_s_d      <= 1'b0;
            req_seen     <= 1'b0;
            samp         <= '0;
            cnt          <= '0;
            wait_cnt     <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            ack_q        <= 1'b0;
            err_unst_q   <= 1'b0;
            err_prot_q   <= 1'b0;
        end else begin
            req_sync   <= {req_sync[SYNC_STAGES-2:0], bus.req_tgl_async};
            req_s_d    <= req_s;
            err_unst_q <= 1'b0;
            // Any request movement while a word is in flight is a sender error;
            // the pending level is still honoured once we are back in IDLE.
            err_prot_q <= (req_s != req_s_d) && (state != IDLE);

            case (state)
                IDLE: begin
                    if (req_s != req_seen) begin
                        req_seen <= req_s;
                        samp     <= bus.data_async;
                        cnt      <= '0;
                        wait_cnt <= '0;
                        state    <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    samp     <= bus.data_async;
                    wait_cnt <= wait_nxt;
                    cnt      <= same ? cnt + CW'(1) : '0;
                    if (same && cnt == STABLE_LAST) begin
                        data_out_q   <= bus.data_async;
                        data_valid_q <= 1'b1;
                        state        <= VALID;
                    end else if (wait_nxt == WAIT_LAST) begin
                        err_unst_q <= 1'b1;
                        ack_q      <= ~ack_q;
                        state      <= IDLE;
                    end
                end
                VALID: begin
                    if (bus.out_ready) begin
                        data_valid_q <= 1'b0;
                        ack_q        <= ~ack_q;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_out     = data_out_q;
    assign bus.data_valid   = data_valid_q;
    assign bus.ack_tgl      = ack_q;
    assign bus.busy         = (state != IDLE);
    assign bus.err_unstable = err_unst_q;
    assign bus.err_protocol = err_prot_q;
endmodule

// File: tb/tb_cdc_bus_rx.sv
// Bench for cdc_bus_rx: default instance plus an 8-bit / 3-stage / 1-stable instance,
// words pushed to a scoreboard on send and popped on each valid&ready handshake.
module tb_cdc_bus_rx;
    logic Hclk   = 1'b0;
    logic Hreset = 1'b1;
    always #5 Hclk = ~Hclk;

    cdc_bus_rx_if #(.WIDTH(32)) b1 ();
    cdc_bus_rx_if #(.WIDTH(8))  b2 ();

    cdc_bus_rx #(.WIDTH(32), .SYNC_STAGES(2), .STABLE_CYCLES(2), .MAX_WAIT(8)) dut (
        .Hclk(Hclk), .Hreset(Hreset), .bus(b1)
    );
    cdc_bus_rx #(.WIDTH(8), .SYNC_STAGES(3), .STABLE_CYCLES(1), .MAX_WAIT(8)) dut2 (
        .Hclk(Hclk), .Hreset(Hreset), .bus(b2)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_unst  = 0;
    int n_prot  = 0;
    int n_hs1   = 0;
    int p0, hs0, u0;
    logic exp_ack;
    logic [31:0] q1[$];
    logic [7:0]  q2[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Hclk);
        #1;
    endtask

    task automatic send1(input logic [31:0] d, input bit push);
        b1.data_async    = d;
        b1.req_tgl_async = ~b1.req_tgl_async;
        if (push) q1.push_back(d);
    endtask

    // Scoreboard side: compare on every handshake the DUT will see at the next edge.
    always @(negedge Hclk) begin
        if (!Hreset) begin
            if (b1.data_valid && b1.out_ready) begin
                chk("sb1_pending", q1.size() != 0, 1);
                if (q1.size() != 0) chk("sb1_data", b1.data_out, q1.pop_front());
                n_hs1 <= n_hs1 + 1;
            end
            if (b2.data_valid && b2.out_ready) begin
                chk("sb2_pending", q2.size() != 0, 1);
                if (q2.size() != 0) chk("sb2_data", {24'h0, b2.data_out}, {24'h0, q2.pop_front()});
            end
            if (b1.err_unstable) n_unst <= n_unst + 1;
            if (b1.err_protocol) n_prot <= n_prot + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        b1.req_tgl_async = 1'b0; b1.data_async = '0; b1.out_ready = 1'b1;
        b2.req_tgl_async = 1'b0; b2.data_async = '0; b2.out_ready = 1'b1;
        exp_ack = 1'b0;

        // reset
        Hreset = 1'b1;
        tick(3);
        chk("rst_data_out", b1.data_out, 0);
        chk("rst_valid", b1.data_valid, 0);
        chk("rst_ack", b1.ack_tgl, 0);
        chk("rst_busy", b1.busy, 0);
        chk("rst_err_unst", b1.err_unstable, 0);
        chk("rst_err_prot", b1.err_protocol, 0);
        chk("rst2_outs", {b2.data_out, b2.data_valid, b2.ack_tgl, b2.busy}, 0);
        Hreset = 1'b0;
        tick(20);
        chk("idle_outs", {b1.data_valid, b1.ack_tgl, b1.busy, b1.err_unstable, b1.err_protocol}, 0);
        chk("idle_data_out", b1.data_out, 0);

        // basic transfer, ready tied high: valid at k+4 only, ack at k+5
        send1(32'hA5A5_1234, 1);
        tick(3);
        chk("basic_busy_k2", b1.busy, 1);
        chk("basic_valid_k2", b1.data_valid, 0);
        tick(1);
        chk("basic_valid_k3", b1.data_valid, 0);
        tick(1);
        chk("basic_valid_k4", b1.data_valid, 1);
        chk("basic_data_k4", b1.data_out, 32'hA5A5_1234);
        chk("basic_ack_k4", b1.ack_tgl, exp_ack);
        tick(1);
        exp_ack = ~exp_ack;
        chk("basic_valid_k5", b1.data_valid, 0);
        chk("basic_ack_k5", b1.ack_tgl, exp_ack);
        chk("basic_busy_k5", b1.busy, 0);

        // backpressure: ready low until k+10
        b1.out_ready = 1'b0;
        send1(32'h0BAD_F00D, 1);
        tick(5);
        chk("bp_valid_k4", b1.data_valid, 1);
        tick(5);
        chk("bp_valid_k9", b1.data_valid, 1);
        chk("bp_data_k9", b1.data_out, 32'h0BAD_F00D);
        chk("bp_ack_k9", b1.ack_tgl, exp_ack);
        b1.out_ready = 1'b1;
        tick(1);
        exp_ack = ~exp_ack;
        chk("bp_valid_k10", b1.data_valid, 0);
        chk("bp_ack_k10", b1.ack_tgl, exp_ack);

        // instability: data moves every cycle, abort at k+9
        hs0 = n_hs1; u0 = n_unst;
        send1(32'h1111_0000, 0);
        for (int i = 1; i <= 9; i++) begin
            tick(1);
            b1.data_async = 32'h1111_0000 + i;
        end
        chk("unst_err_k8", b1.err_unstable, 0);
        chk("unst_busy_k8", b1.busy, 1);
        tick(1);
        b1.data_async = 32'h2222_0000;
        exp_ack = ~exp_ack;
        chk("unst_err_k9", b1.err_unstable, 1);
        chk("unst_busy_k9", b1.busy, 0);
        chk("unst_ack_k9", b1.ack_tgl, exp_ack);
        chk("unst_data_kept", b1.data_out, 32'h0BAD_F00D);
        tick(1);
        chk("unst_err_k10", b1.err_unstable, 0);
        chk("unst_pulses", n_unst, u0 + 1);
        chk("unst_no_valid", n_hs1, hs0);
        chk("unst_valid_k10", b1.data_valid, 0);

        // protocol error: one extra toggle during capture
        p0 = n_prot;
        send1(32'h3333_3333, 1);
        tick(3);
        b1.req_tgl_async = ~b1.req_tgl_async;
        tick(2);
        chk("prot_valid_k4", b1.data_valid, 1);
        chk("prot_data_k4", b1.data_out, 32'h3333_3333);
        b1.data_async = 32'h4444_4444;
        q1.push_back(32'h4444_4444);
        tick(1);
        exp_ack = ~exp_ack;
        chk("prot_err_k5", b1.err_protocol, 1);
        chk("prot_ack_k5", b1.ack_tgl, exp_ack);
        chk("prot_busy_k5", b1.busy, 0);
        tick(1);
        chk("prot_err_k6", b1.err_protocol, 0);
        chk("prot_recap_busy_k6", b1.busy, 1);
        tick(2);
        chk("prot_valid2_k8", b1.data_valid, 1);
        chk("prot_data2_k8", b1.data_out, 32'h4444_4444);
        tick(1);
        exp_ack = ~exp_ack;
        chk("prot_ack2_k9", b1.ack_tgl, exp_ack);
        chk("prot_pulses", n_prot, p0 + 1);

        // two extra toggles: two error pulses, no second capture
        p0 = n_prot; hs0 = n_hs1;
        b1.out_ready = 1'b0;
        send1(32'h5555_AAAA, 1);
        tick(3);
        b1.req_tgl_async = ~b1.req_tgl_async;
        tick(2);
        chk("prot2_valid_k4", b1.data_valid, 1);
        chk("prot2_data_k4", b1.data_out, 32'h5555_AAAA);
        b1.req_tgl_async = ~b1.req_tgl_async;
        tick(5);
        b1.out_ready = 1'b1;
        tick(1);
        exp_ack = ~exp_ack;
        chk("prot2_ack_k10", b1.ack_tgl, exp_ack);
        tick(10);
        chk("prot2_busy", b1.busy, 0);
        chk("prot2_pulses", n_prot, p0 + 2);
        chk("prot2_one_word", n_hs1, hs0 + 1);

        // reset while VALID
        b1.out_ready = 1'b0;
        send1(32'h6666_7777, 1);
        tick(5);
        chk("rv_valid_k4", b1.data_valid, 1);
        Hreset = 1'b1;
        b1.req_tgl_async = 1'b0;
        b2.req_tgl_async = 1'b0;
        tick(1);
        chk("rv_valid", b1.data_valid, 0);
        chk("rv_ack", b1.ack_tgl, 0);
        chk("rv_data_out", b1.data_out, 0);
        chk("rv_busy", b1.busy, 0);
        q1.delete();
        exp_ack = 1'b0;
        Hreset = 1'b0;
        b1.out_ready = 1'b1;
        tick(3);

        // parameter sweep instance: valid at k+4
        b2.data_async    = 8'h5C;
        b2.req_tgl_async = ~b2.req_tgl_async;
        q2.push_back(8'h5C);
        tick(4);
        chk("p2_valid_k3", b2.data_valid, 0);
        chk("p2_busy_k3", b2.busy, 1);
        tick(1);
        chk("p2_valid_k4", b2.data_valid, 1);
        chk("p2_data_k4", {24'h0, b2.data_out}, 32'h5C);
        tick(1);
        chk("p2_valid_k5", b2.data_valid, 0);
        chk("p2_ack_k5", b2.ack_tgl, 1);

        tick(2);
        chk("sb1_drained", q1.size(), 0);
        chk("sb2_drained", q2.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
